// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// AXI response code and the default boot address.
package ifu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_HOLD = 2'd3
  } ifu_state_e;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] INST_BYTES       = 32'd4;

  // Sequential next PC; 32-bit add so 32'hFFFFFFFC wraps to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + INST_BYTES;
  endfunction

endpackage

// File: rtl/ifu_pc_sel.sv
// Next-PC / redirect bookkeeping for ifu_fetch: decides the next fetch PC,
// the pending redirect target and whether the in-flight response is dropped.
module ifu_pc_sel
  import ifu_pkg::*;
(
  input  ifu_state_e  i_state,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pend_pc,
  input  logic        i_squash,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_rvalid,
  input  logic        i_handshake,
  output logic [31:0] o_pc_nxt,
  output logic [31:0] o_pend_nxt,
  output logic        o_squash_nxt,
  output logic        o_discard,
  output logic [31:0] o_snpc
);

  logic        w_squash_eff;
  logic [31:0] w_target;

  assign o_snpc = next_seq_pc(i_pc);

  // A redirect arriving in the same cycle as the response counts as pending.
  assign w_squash_eff = i_squash | i_redirect_valid;
  assign w_target     = i_redirect_valid ? i_redirect_pc : i_pend_pc;

  always_comb begin
    o_pc_nxt     = i_pc;
    o_pend_nxt   = i_pend_pc;
    o_squash_nxt = i_squash;
    o_discard    = 1'b0;
    case (i_state)
      ST_IDLE: begin
        if (i_redirect_valid) begin
          o_pc_nxt = i_redirect_pc;
        end
      end
      ST_ADDR: begin
        // araddr must not move while arvalid is high; park the target.
        if (i_redirect_valid) begin
          o_pend_nxt   = i_redirect_pc;
          o_squash_nxt = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_rvalid && w_squash_eff) begin
          o_discard    = 1'b1;
          o_pc_nxt     = w_target;
          o_squash_nxt = 1'b0;
        end else if (i_redirect_valid) begin
          o_pend_nxt   = i_redirect_pc;
          o_squash_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        if (i_redirect_valid) begin
          o_pc_nxt = i_redirect_pc;
        end else if (i_handshake) begin
          o_pc_nxt = o_snpc;
        end
      end
      default: begin
        o_pc_nxt = i_pc;
      end
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AXI4-Lite read per instruction, hands
// {inst, pc, snpc, fault} to decode and re-steers on redirects.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instF,
  output logic [31:0] pcF,
  output logic [31:0] snpcF,
  output logic        faultF,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; valid, once raised, holds its payload until that transfer.
  ifu_state_e  r_state;
  ifu_state_e  w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pend_pc;
  logic        r_squash;
  logic [31:0] r_inst;
  logic [31:0] r_pc_f;
  logic [31:0] r_snpc_f;
  logic        r_fault;

  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_nxt;
  logic        w_squash_nxt;
  logic        w_discard;
  logic [31:0] w_snpc;
  logic        w_handshake;
  logic        w_capture;
  logic        w_resp_ok;

  assign arvalid     = (r_state == ST_ADDR);
  assign rready      = (r_state == ST_DATA);
  assign out_valid   = (r_state == ST_HOLD) && !redirect_valid;
  assign w_handshake = out_valid && out_ready;
  assign araddr      = r_pc;
  assign instF       = r_inst;
  assign pcF         = r_pc_f;
  assign snpcF       = r_snpc_f;
  assign faultF      = r_fault;
  assign dbg_state   = r_state;

  ifu_pc_sel u_pc_sel (
    .i_state          (r_state),
    .i_pc             (r_pc),
    .i_pend_pc        (r_pend_pc),
    .i_squash         (r_squash),
    .i_redirect_valid (redirect_valid),
    .i_redirect_pc    (redirect_pc),
    .i_rvalid         (rvalid),
    .i_handshake      (w_handshake),
    .o_pc_nxt         (w_pc_nxt),
    .o_pend_nxt       (w_pend_nxt),
    .o_squash_nxt     (w_squash_nxt),
    .o_discard        (w_discard),
    .o_snpc           (w_snpc)
  );

  assign w_capture = (r_state == ST_DATA) && rvalid && !w_discard;
  assign w_resp_ok = (rresp == RESP_OKAY);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        if (arready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (rvalid) begin
          w_state_nxt = w_discard ? ST_ADDR : ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_handshake || redirect_valid) begin
          w_state_nxt = ST_ADDR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
      r_squash  <= 1'b0;
      r_inst    <= 32'h0;
      r_pc_f    <= RESET_PC;
      r_snpc_f  <= next_seq_pc(RESET_PC);
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_nxt;
      r_squash  <= w_squash_nxt;
      if (w_capture) begin
        // A faulting fetch delivers a zero word so decode never sees junk.
        r_inst   <= w_resp_ok ? rdata : 32'h0;
        r_fault  <= !w_resp_ok;
        r_pc_f   <= r_pc;
        r_snpc_f <= w_snpc;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: behavioural AXI4-Lite memory, directed
// redirect/fault/wrap cases, a short random phase and an expected-output queue.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic [1:0]  rresp = 2'b00;
  logic        rvalid = 1'b0;
  logic        rready;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instF;
  logic [31:0] pcF;
  logic [31:0] snpcF;
  logic        faultF;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {fault, inst, pc, snpc}
  logic [96:0] exp_q[$];

  int          ar_wait = 0;
  int          r_wait = 0;
  logic [31:0] fault_addr = 32'h0000_0001;

  // memory model state
  logic        m_pending = 1'b0;
  logic [31:0] m_req = 32'h0;
  int          m_ar_cnt = 0;
  int          m_r_cnt = 0;

  // monitor state
  logic        mon_prev_stall = 1'b0;
  logic [31:0] mon_prev_addr = 32'h0;
  logic [96:0] mon_e;

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instF          (instF),
    .pcF            (pcF),
    .snpcF          (snpcF),
    .faultF         (faultF),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h8000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory model (drives at negedge) ----------------
  initial begin : mem_model
    forever begin
      @(negedge clk);
      arready = 1'b0;
      rvalid  = 1'b0;
      rdata   = 32'h0;
      rresp   = 2'b00;
      if (rst) begin
        m_pending = 1'b0;
        m_ar_cnt  = 0;
        m_r_cnt   = 0;
      end else if (!m_pending) begin
        if (arvalid) begin
          if (m_ar_cnt >= ar_wait) begin
            arready   = 1'b1;
            m_pending = 1'b1;
            m_req     = araddr;
            m_ar_cnt  = 0;
            m_r_cnt   = 0;
          end else begin
            m_ar_cnt++;
          end
        end
      end else if (rready) begin
        if (m_r_cnt >= r_wait) begin
          rvalid    = 1'b1;
          m_pending = 1'b0;
          if (m_req == fault_addr) begin
            rresp = 2'b10;
            rdata = 32'hDEAD_BEEF;
          end else begin
            rdata = mem_word(m_req);
          end
        end else begin
          m_r_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard consumer / protocol monitor ----------------
  initial begin : monitor
    forever begin
      @(negedge clk);
      #3;
      if (mon_prev_stall && arvalid) check_val("araddr_stable", araddr, mon_prev_addr);
      mon_prev_stall = arvalid && !arready;
      mon_prev_addr  = araddr;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_out", 32'(out_valid), 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          check_val("out_fault", 32'(faultF), 32'(mon_e[96]));
          check_val("out_inst", instF, mon_e[95:64]);
          check_val("out_pc", pcF, mon_e[63:32]);
          check_val("out_snpc", snpcF, mon_e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin
      step();
      n++;
    end
    check_val(tag, 32'(out_valid), 32'h1);
  endtask

  task automatic fetch_one(input logic [31:0] pc, input logic flt, input int hold);
    logic [31:0] inst;
    inst = flt ? 32'h0 : mem_word(pc);
    exp_q.push_back({flt, inst, pc, pc + 32'd4});
    wait_out_valid("fetch_timeout");
    for (int i = 0; i < hold; i++) begin
      step();
      check_val("hold_valid", 32'(out_valid), 32'h1);
      check_val("hold_no_ar", 32'(arvalid), 32'h0);
      check_val("hold_pc", pcF, pc);
      check_val("hold_inst", instF, inst);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin : main
    int n;
    logic [31:0] pc;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check_val("rst_arvalid", 32'(arvalid), 32'h0);
    check_val("rst_rready", 32'(rready), 32'h0);
    check_val("rst_out_valid", 32'(out_valid), 32'h0);
    check_val("rst_instF", instF, 32'h0);
    check_val("rst_pcF", pcF, 32'h8000_0000);
    check_val("rst_snpcF", snpcF, 32'h8000_0004);
    check_val("rst_faultF", 32'(faultF), 32'h0);
    rst = 1'b0;

    // first fetch: arvalid one cycle after reset release, out_valid 2 later
    step();
    check_val("first_arvalid", 32'(arvalid), 32'h1);
    check_val("first_araddr", araddr, 32'h8000_0000);
    step();
    check_val("first_rready", 32'(rready), 32'h1);
    step();
    check_val("first_out_valid", 32'(out_valid), 32'h1);
    fetch_one(32'h8000_0000, 1'b0, 0);
    check_val("seq_arvalid", 32'(arvalid), 32'h1);
    check_val("seq_araddr", araddr, 32'h8000_0004);

    // decode stall in HOLD for 5 cycles; arm a 3-cycle AR stall for the next fetch
    ar_wait = 3;
    fetch_one(32'h8000_0004, 1'b0, 5);

    // two redirects during a stalled ADDR: last one wins, old request completes
    check_val("t3_arvalid", 32'(arvalid), 32'h1);
    check_val("t3_araddr", araddr, 32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0F00;
    step();
    redirect_pc    = 32'h8000_1000;
    step();
    redirect_valid = 1'b0;
    check_val("t3_arvalid_held", 32'(arvalid), 32'h1);
    check_val("t3_araddr_held", araddr, 32'h8000_0008);
    n = 0;
    while (!rready && n < 50) begin
      step();
      check_val("t3_no_out", 32'(out_valid), 32'h0);
      n++;
    end
    check_val("t3_data", 32'(rready), 32'h1);
    ar_wait = 0;
    n = 0;
    while (!arvalid && n < 50) begin
      step();
      check_val("t3_no_out", 32'(out_valid), 32'h0);
      n++;
    end
    check_val("t3_new_arvalid", 32'(arvalid), 32'h1);
    check_val("t3_redir_addr", araddr, 32'h8000_1000);
    fetch_one(32'h8000_1000, 1'b0, 0);

    // redirect in HOLD together with out_ready: nothing transferred
    wait_out_valid("t4_hold_timeout");
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    #1;
    check_val("t4_out_gated", 32'(out_valid), 32'h0);
    step();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    check_val("t4_state", 32'(dbg_state), 32'(ST_ADDR));
    check_val("t4_araddr", araddr, 32'h8000_2000);

    // fault response, then sequential fetch continues at snpc
    fault_addr = 32'h8000_2004;
    fetch_one(32'h8000_2000, 1'b0, 0);
    fetch_one(32'h8000_2004, 1'b1, 1);
    fetch_one(32'h8000_2008, 1'b0, 0);

    // redirect coinciding with rvalid in DATA, to the wrap address
    step();
    check_val("t6_in_data", 32'(rready), 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check_val("t6_arvalid", 32'(arvalid), 32'h1);
    check_val("t6_araddr", araddr, 32'hFFFF_FFFC);
    fetch_one(32'hFFFF_FFFC, 1'b0, 0);
    check_val("wrap_arvalid", 32'(arvalid), 32'h1);
    check_val("wrap_araddr", araddr, 32'h0);
    fetch_one(32'h0, 1'b0, 0);

    // random memory latency and decode back-pressure
    pc = 32'h4;
    for (int i = 0; i < 16; i++) begin
      ar_wait = $urandom_range(0, 2);
      r_wait  = $urandom_range(0, 2);
      fetch_one(pc, 1'b0, $urandom_range(0, 3));
      pc = pc + 32'd4;
    end

    repeat (3) step();
    check_val("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit that sits upstream of the decode pipeline register. It holds the architectural fetch PC and issues one AXI4-Lite read per instruction to instruction memory. It presents `{inst, pc, snpc}` to decode over a valid/ready handshake. Redirects from later stages on jumps, branches and traps re-steer it, and wrong-path fetches already in flight are squashed.

## Interface
- `RESET_PC`, default 32'h80000000, first fetch address after reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `araddr`  out  32  read address, equals current fetch PC.
- `arvalid`  out  1  read address valid.
- `arready`  in  1  memory accepts address.
- `rdata`  in  32  read data.
- `rresp`  in  2  read response; 2'b00 OKAY, anything else is a fault.
- `rvalid`  in  1  read data valid.
- `rready`  out  1  fetch accepts data.
- `redirect_valid`  in  1  one-cycle pulse: the next fetch address is `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `instF`  out  32  fetched instruction.
- `pcF`  out  32  PC of `instF`.
- `snpcF`  out  32  `pcF + 4`.
- `faultF`  out  1  instruction-access fault for `instF`.
- `out_valid`  out  1  `instF`/`pcF`/`snpcF`/`faultF` are valid.
- `out_ready`  in  1  decode register accepts.

## Operation
- States:
  - IDLE, the reset state.
  - ADDR: `arvalid=1`.
  - DATA: `rready=1`.
  - HOLD: `out_valid=1` unless squashed.
- Transitions:
  - IDLE→ADDR unconditionally.
  - ADDR→DATA on `arvalid&arready`.
  - DATA→HOLD on `rvalid` if no squash is pending.
  - DATA→ADDR on `rvalid` if squash is pending; the response is discarded.
  - HOLD→ADDR on `out_valid&out_ready`, or on `redirect_valid`.
- PC update:
  - On leaving HOLD by handshake: `pc <= snpc`.
  - On any redirect: `pc <= redirect_pc`, subject to the ADDR rule below.
- `snpc = pc + 32'd4`, 32-bit, wraps modulo 2^32: `pc=32'hFFFFFFFC` gives `snpc=0`.
- Capture in DATA on `rvalid`:
  - `rresp==0`: `instF <= rdata`, `faultF <= 0`.
  - Otherwise: `instF <= 32'h0`, `faultF <= 1`.
- Redirect in IDLE: `pc <= redirect_pc` before the first ADDR.
- Redirect in ADDR:
  - AXI forbids changing `araddr` while `arvalid` is high, so the redirect is latched into `pend_pc` and `squash` is set.
  - The current request completes, and its data is discarded in DATA.
  - Next ADDR uses `pend_pc`.
  - If the redirect coincides with `arready`, it is handled identically.
- Redirect in DATA:
  - `squash <= 1`, `pend_pc <= redirect_pc`.
  - If it coincides with `rvalid`, the data is discarded that same cycle.
- Redirect in HOLD: `out_valid` is forced low combinationally in that cycle, so no transfer occurs even if `out_ready=1`. Next state is ADDR at `redirect_pc`.
- Multiple redirects before the squash resolves: the last one wins.
- `squash` clears when the discarded response is consumed.
- Outputs `instF`/`pcF`/`snpcF`/`faultF` hold stable throughout HOLD.
- `araddr = pc` is stable throughout ADDR.
- Reset mid-transaction: state returns to IDLE and `pc`, `squash` and outputs are reset. An outstanding memory response arriving after reset is not the fetch unit's responsibility; the memory is reset by the same `rst`.

## Timing
- Reset values:
  - `state=IDLE`, `pc=RESET_PC`, `squash=0`.
  - `arvalid=0`, `rready=0`, `out_valid=0`.
  - `instF=0`, `pcF=RESET_PC`, `snpcF=RESET_PC+4`, `faultF=0`.
- `arvalid` first asserts 1 cycle after `rst` deasserts.
- Latency with zero-wait memory (`arready` and `rvalid` each high on the first cycle): ADDR, DATA, then HOLD. `out_valid` rises 2 cycles after `arvalid` rises.
- Throughput with always-ready decode: one instruction per 3 cycles (ADDR, DATA, HOLD). No overlap of requests.
- `out_valid`, `arvalid` and `rready` are decoded from state. The only combinational input dependency is `redirect_valid` gating `out_valid`.
- All registers update on `posedge clk`.

## Structure
- Shared package `ifu_pkg`:
  - State encoding (2 bits: IDLE/ADDR/DATA/HOLD).
  - `RESP_OKAY=2'b00`.
  - Default `RESET_PC`.
- Single module, no sub-module required.
- PC/redirect logic may be split into `ifu_pc_sel` if the block grows (e.g. for a predictor).

## Test plan
- Reset release, memory returns `rdata=32'h00000013`, `rresp=0`, zero wait, `out_ready=1` → first `arvalid` cycle after reset has `araddr=32'h80000000`; `out_valid` with `instF=32'h00000013`, `pcF=32'h80000000`, `snpcF=32'h80000004`; next `araddr=32'h80000004`.
- `out_ready=0` for 5 cycles in HOLD → `out_valid` stays 1 and outputs are unchanged; no new `arvalid` until the handshake.
- `redirect_valid` with `redirect_pc=32'h80001000` while in ADDR with `arready` stalled 3 cycles → `araddr` stays at the old PC until accepted; the response is dropped with no `out_valid`; next `araddr=32'h80001000`.
- `redirect_valid` in HOLD coinciding with `out_ready=1` → `out_valid=0` that cycle; next fetch at `redirect_pc`; the held instruction is never delivered.
- `rresp=2'b10` → `faultF=1`, `instF=0`, `out_valid=1`; the following fetch proceeds at `snpc`.
- Wrap: redirect to `32'hFFFFFFFC` → `snpcF=0`; next `araddr=0`.
